// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the single-bus Datapath2.
// One state per clock; strobes are registered decodes of the next state.
module control_sequencer #(
  parameter logic [4:0] ALU_ADD = 5'd2,
  parameter logic [4:0] ALU_INC = 5'd12
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        ConOtp,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        BAout,
  output logic        Cout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  OpCode,
  output logic        run,
  output logic        illegal
);

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [4:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_DEC,
    S_R1, S_R2, S_R3,
    S_LDI1, S_LDI2, S_LDI3,
    S_LD1, S_LD2, S_LD3, S_LD4, S_LD5,
    S_ST1, S_ST2, S_ST3, S_ST4, S_ST5,
    S_B1, S_B2, S_B3, S_B4T, S_B4N,
    S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       ba_out;
    logic       c_out;
    logic       r_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       r_in;
    logic       con_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rd;
    logic       wr;
    logic [4:0] op;
    logic       run;
  } ctrl_t;

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl_q;
  logic [4:0] opcode;
  logic       unused_ir_bits;

  assign opcode         = IR[31:27];
  assign unused_ir_bits = ^IR[26:0];

  function automatic logic is_defined(input logic [4:0] op);
    return (op <= 5'd11) || (op == OP_BR) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  function automatic state_t next_state(input state_t s, input logic [4:0] op,
                                        input logic rdy, input logic con);
    state_t n;
    // NOTE: every path assigns n before any branch so no storage is implied.
    n = s;
    case (s)
      S_RESET: n = S_T0;
      S_T0:    n = S_T1;
      S_T1:    n = S_T2;
      S_T2:    n = rdy ? S_T3 : S_T2;
      S_T3:    n = S_DEC;
      S_DEC: begin
        if (op == OP_LD)                     n = S_LD1;
        else if (op == OP_LDI)               n = S_LDI1;
        else if (op == OP_ST)                n = S_ST1;
        else if (op >= 5'd3 && op <= 5'd11)  n = S_R1;
        else if (op == OP_BR)                n = S_B1;
        else if (op == OP_HALT)              n = S_HALT;
        else                                 n = S_T0;
      end
      S_R1:   n = S_R2;
      S_R2:   n = S_R3;
      S_LDI1: n = S_LDI2;
      S_LDI2: n = S_LDI3;
      S_LD1:  n = S_LD2;
      S_LD2:  n = S_LD3;
      S_LD3:  n = S_LD4;
      S_LD4:  n = rdy ? S_LD5 : S_LD4;
      S_ST1:  n = S_ST2;
      S_ST2:  n = S_ST3;
      S_ST3:  n = S_ST4;
      S_ST4:  n = S_ST5;
      S_ST5:  n = rdy ? S_T0 : S_ST5;
      S_B1:   n = S_B2;
      S_B2:   n = S_B3;
      // CON was latched two states ago, so ConOtp is settled here.
      S_B3:   n = con ? S_B4T : S_B4N;
      S_HALT: n = S_HALT;
      S_R3, S_LDI3, S_LD5, S_B4T, S_B4N: n = S_T0;
      default: n = S_RESET;
    endcase
    return n;
  endfunction

  function automatic ctrl_t decode(input state_t s, input logic [4:0] op);
    ctrl_t c;
    c     = '0;
    c.run = (s != S_RESET) && (s != S_HALT);
    case (s)
      S_T0:          begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.z_in = 1'b1; c.op = ALU_INC; end
      S_T1, S_B4T:   begin c.zlow_out = 1'b1; c.pc_in = 1'b1; end
      S_T2, S_LD4:   begin c.rd = 1'b1; c.mdr_in = 1'b1; end
      S_T3:          begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_R1:          begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
      S_R2:          begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.op = op; end
      S_R3, S_LDI3:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_LDI1, S_LD1, S_ST1:
                     begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
      S_LDI2, S_LD2, S_ST2, S_B3:
                     begin c.c_out = 1'b1; c.z_in = 1'b1; c.op = ALU_ADD; end
      S_LD3, S_ST3:  begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
      S_LD5:         begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_ST4:         begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
      S_ST5:         c.wr = 1'b1;
      S_B1:          begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
      S_B2:          begin c.pc_out = 1'b1; c.y_in = 1'b1; end
      default:       ;
    endcase
    return c;
  endfunction

  assign state_nxt = next_state(state, opcode, mem_ready, ConOtp);

  // NOTE: state and strobe registers use non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= S_RESET;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode(state_nxt, opcode);
    end
  end

  assign PCout   = ctrl_q.pc_out;
  assign Zlowout = ctrl_q.zlow_out;
  assign MDRout  = ctrl_q.mdr_out;
  assign BAout   = ctrl_q.ba_out;
  assign Cout    = ctrl_q.c_out;
  assign Rout    = ctrl_q.r_out;
  assign MARin   = ctrl_q.mar_in;
  assign Zin     = ctrl_q.z_in;
  assign PCin    = ctrl_q.pc_in;
  assign MDRin   = ctrl_q.mdr_in;
  assign IRin    = ctrl_q.ir_in;
  assign Yin     = ctrl_q.y_in;
  assign Rin     = ctrl_q.r_in;
  assign CONin   = ctrl_q.con_in;
  assign Gra     = ctrl_q.gra;
  assign Grb     = ctrl_q.grb;
  assign Grc     = ctrl_q.grc;
  assign Read    = ctrl_q.rd;
  assign Write   = ctrl_q.wr;
  assign OpCode  = ctrl_q.op;
  assign run     = ctrl_q.run;

  // IR is only valid once DEC is entered, so this flag reads it directly.
  assign illegal = (state == S_DEC) && !is_defined(opcode);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues the expected strobe word for each cycle,
// a negedge monitor pops and compares it against the sequencer outputs.
module tb_control_sequencer;

  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_INC = 5'd12;

  localparam logic [20:0] M_PCOUT  = 21'(1) << 20;
  localparam logic [20:0] M_ZLOW   = 21'(1) << 19;
  localparam logic [20:0] M_MDROUT = 21'(1) << 18;
  localparam logic [20:0] M_BAOUT  = 21'(1) << 17;
  localparam logic [20:0] M_COUT   = 21'(1) << 16;
  localparam logic [20:0] M_ROUT   = 21'(1) << 15;
  localparam logic [20:0] M_MARIN  = 21'(1) << 14;
  localparam logic [20:0] M_ZIN    = 21'(1) << 13;
  localparam logic [20:0] M_PCIN   = 21'(1) << 12;
  localparam logic [20:0] M_MDRIN  = 21'(1) << 11;
  localparam logic [20:0] M_IRIN   = 21'(1) << 10;
  localparam logic [20:0] M_YIN    = 21'(1) << 9;
  localparam logic [20:0] M_RIN    = 21'(1) << 8;
  localparam logic [20:0] M_CONIN  = 21'(1) << 7;
  localparam logic [20:0] M_GRA    = 21'(1) << 6;
  localparam logic [20:0] M_GRB    = 21'(1) << 5;
  localparam logic [20:0] M_GRC    = 21'(1) << 4;
  localparam logic [20:0] M_RD     = 21'(1) << 3;
  localparam logic [20:0] M_WR     = 21'(1) << 2;
  localparam logic [20:0] M_RUN    = 21'(1) << 1;
  localparam logic [20:0] M_ILL    = 21'(1) << 0;

  typedef struct {
    string       name;
    logic [20:0] strobes;
    logic [4:0]  op;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR = '0;
  logic        ConOtp;
  logic        mem_ready;
  logic [31:0] mem_word;
  logic PCout, Zlowout, MDRout, BAout, Cout, Rout, MARin, Zin, PCin, MDRin, IRin;
  logic Yin, Rin, CONin, Gra, Grb, Grc, Read, Write, run, illegal;
  logic [4:0] OpCode;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  control_sequencer #(.ALU_ADD(ALU_ADD), .ALU_INC(ALU_INC)) dut (
    .clk(clk), .clr(clr), .IR(IR), .ConOtp(ConOtp), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
    .Cout(Cout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Read(Read), .Write(Write),
    .OpCode(OpCode), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Minimal datapath stand-in: IR loads the memory word on an IRin edge.
  always @(posedge clk) if (IRin) IR <= mem_word;

  task automatic check(input string nm, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got strobes=%h op=%0d, expected strobes=%h op=%0d",
               nm, act[25:5], act[4:0], exp[25:5], exp[4:0]);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name,
            {PCout, Zlowout, MDRout, BAout, Cout, Rout, MARin, Zin, PCin, MDRin, IRin,
             Yin, Rin, CONin, Gra, Grb, Grc, Read, Write, run, illegal, OpCode},
            {e.strobes, e.op});
    end
  end

  task automatic cyc(input string nm, input logic [20:0] s, input logic [4:0] op, input logic mr);
    @(posedge clk);
    #1;
    mem_ready = mr;
    sb.push_back('{nm, s, op});
  endtask

  task automatic fetch(input logic [31:0] word, input int t2_wait, input logic ill);
    mem_word = word;
    cyc("T0", M_PCOUT | M_MARIN | M_ZIN | M_RUN, ALU_INC, 1'b1);
    cyc("T1", M_ZLOW | M_PCIN | M_RUN, 5'd0, 1'b1);
    for (int i = 0; i < t2_wait; i++) cyc("T2_wait", M_RD | M_MDRIN | M_RUN, 5'd0, 1'b0);
    cyc("T2", M_RD | M_MDRIN | M_RUN, 5'd0, 1'b1);
    cyc("T3", M_MDROUT | M_IRIN | M_RUN, 5'd0, 1'b1);
    cyc("DEC", M_RUN | (ill ? M_ILL : 21'd0), 5'd0, 1'b1);
  endtask

  task automatic exec_r(input logic [4:0] op);
    cyc("R_E1", M_GRB | M_ROUT | M_YIN | M_RUN, 5'd0, 1'b1);
    cyc("R_E2", M_GRC | M_ROUT | M_ZIN | M_RUN, op, 1'b1);
    cyc("R_E3", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0, 1'b1);
  endtask

  task automatic exec_addr(input string tag);
    cyc({tag, "_E1"}, M_GRB | M_BAOUT | M_YIN | M_RUN, 5'd0, 1'b1);
    cyc({tag, "_E2"}, M_COUT | M_ZIN | M_RUN, ALU_ADD, 1'b1);
  endtask

  task automatic exec_br(input logic con);
    ConOtp = con;
    cyc("BR_E1", M_GRA | M_ROUT | M_CONIN | M_RUN, 5'd0, 1'b1);
    cyc("BR_E2", M_PCOUT | M_YIN | M_RUN, 5'd0, 1'b1);
    cyc("BR_E3", M_COUT | M_ZIN | M_RUN, ALU_ADD, 1'b1);
    cyc("BR_E4", (con ? (M_ZLOW | M_PCIN) : 21'd0) | M_RUN, 5'd0, 1'b1);
  endtask

  initial begin
    clr = 1'b1; ConOtp = 1'b0; mem_ready = 1'b1; mem_word = '0;
    #1 clr = 1'b0;
    cyc("reset", 21'd0, 5'd0, 1'b1);
    clr = 1'b1;

    fetch(32'h1880_0000, 0, 1'b0);  exec_r(5'd3);      // add
    fetch(32'h5880_0000, 0, 1'b0);  exec_r(5'd11);     // highest R-format opcode
    fetch(32'h0880_0005, 0, 1'b0);  exec_addr("LDI");  // ldi
    cyc("LDI_E3", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0, 1'b1);
    fetch(32'h9B00_0019, 0, 1'b0);  exec_br(1'b1);     // branch taken
    fetch(32'h9B00_0019, 0, 1'b0);  exec_br(1'b0);     // branch not taken

    fetch(32'h0080_0005, 0, 1'b0);  exec_addr("LD");   // ld, 3 waits in E4
    cyc("LD_E3", M_ZLOW | M_MARIN | M_RUN, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("LD_E4_wait", M_RD | M_MDRIN | M_RUN, 5'd0, 1'b0);
    cyc("LD_E4", M_RD | M_MDRIN | M_RUN, 5'd0, 1'b1);
    cyc("LD_E5", M_MDROUT | M_GRA | M_RIN | M_RUN, 5'd0, 1'b1);

    fetch(32'h1080_0005, 2, 1'b0);  exec_addr("ST");   // st, 2 waits in T2, 1 in E5
    cyc("ST_E3", M_ZLOW | M_MARIN | M_RUN, 5'd0, 1'b1);
    cyc("ST_E4", M_GRA | M_ROUT | M_MDRIN | M_RUN, 5'd0, 1'b0);
    cyc("ST_E5_wait", M_WR | M_RUN, 5'd0, 1'b0);
    cyc("ST_E5", M_WR | M_RUN, 5'd0, 1'b1);

    fetch(32'hD000_0000, 0, 1'b0);                     // nop
    fetch(32'hF800_0000, 0, 1'b1);                     // undefined 31
    fetch(32'h6000_0000, 0, 1'b1);                     // 12: first undefined above R-format

    fetch(32'h0080_0005, 0, 1'b0);  exec_addr("LDc");  // clr dropped mid-wait
    cyc("LDc_E3", M_ZLOW | M_MARIN | M_RUN, 5'd0, 1'b1);
    cyc("LDc_E4_wait", M_RD | M_MDRIN | M_RUN, 5'd0, 1'b0);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    #2 clr = 1'b0;
    sb.push_back('{"clr_mid_wait", 21'd0, 5'd0});
    cyc("reset_held", 21'd0, 5'd0, 1'b1);
    clr = 1'b1;

    fetch(32'hD800_0000, 0, 1'b0);                     // halt
    for (int i = 0; i < 20; i++) cyc("halted", 21'd0, 5'd0, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
